// File: rtl/usb_fs_out_arb.sv
// usb_fs_out_arb
// Round-robin arbiter sharing the OUT protocol engine's single endpoint read
// port between up to 16 endpoint consumers. It grants one endpoint at a time
// and forwards that consumer's get strobes to the PE. Bursts are capped so
// other requesters get a turn. Each returned byte is tagged with its
// endpoint number.

module usb_fs_out_arb #(
    parameter int NUM_OUT_EPS = 1,
    parameter int MAX_BURST   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_OUT_EPS-1:0] rd_req,
    input  logic [NUM_OUT_EPS-1:0] rd_get,
    output logic [NUM_OUT_EPS-1:0] rd_grant,
    output logic                   rd_valid,
    output logic [3:0]             rd_ep,
    input  logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
    output logic [NUM_OUT_EPS-1:0] out_ep_grant,
    output logic [NUM_OUT_EPS-1:0] out_ep_data_get
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [5:0] BURST_MAX = 6'(MAX_BURST);
    localparam logic [3:0] LAST_INIT = 4'(NUM_OUT_EPS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             g;
    logic [3:0]             g_nxt;
    logic [3:0]             last;
    logic [3:0]             last_nxt;
    logic [5:0]             burst_cnt;
    logic [5:0]             burst_nxt;

    logic [NUM_OUT_EPS-1:0] eligible;
    logic [NUM_OUT_EPS-1:0] g_onehot;
    logic                   win_found;
    logic [3:0]             win_idx;
    int                     scan_idx;

    logic                   sel_req;
    logic                   sel_avail;
    logic                   sel_get;
    logic                   other_elig;
    logic                   burst_full;
    logic                   fwd_get;

    // A requester only competes when the PE actually has bytes for it.
    assign eligible = rd_req & out_ep_data_avail;

    // Decode the current owner into a one-hot mask.
    // Reducing the inputs through this mask avoids variable bit-selects
    // whose index width would not match small NUM_OUT_EPS.
    always_comb begin
        g_onehot = '0;
        for (int i = 0; i < NUM_OUT_EPS; i++) begin
            g_onehot[i] = (g == 4'(i));
        end
    end

    assign sel_req    = |(rd_req & g_onehot);
    assign sel_avail  = |(out_ep_data_avail & g_onehot);
    assign sel_get    = |(rd_get & g_onehot);
    assign other_elig = |(eligible & ~g_onehot);
    assign burst_full = (burst_cnt == BURST_MAX);

    // Round-robin scan: first eligible index after the previous owner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_OUT_EPS; k++) begin
            scan_idx = (int'(last) + k) % NUM_OUT_EPS;
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = 4'(scan_idx);
            end
        end
    end

    // Next-state, grant and get-forwarding logic for the arbitration FSM.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        last_nxt  = last;
        burst_nxt = burst_cnt;
        rd_grant  = '0;
        fwd_get   = 1'b0;
        case (state)
            IDLE: begin
                burst_nxt = '0;
                if (win_found) begin
                    g_nxt     = win_idx;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                rd_grant = g_onehot;
                fwd_get  = sel_get && sel_avail && (burst_cnt < BURST_MAX);
                if (fwd_get) begin
                    burst_nxt = burst_cnt + 6'd1;
                end
                if (!sel_req || !sel_avail || (burst_full && other_elig)) begin
                    state_nxt = RELEASE;
                    last_nxt  = g;
                end else if (burst_full) begin
                    burst_nxt = '0;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign out_ep_grant    = rd_grant;
    assign out_ep_data_get = fwd_get ? g_onehot : '0;

    // State registers. The byte-valid flag and its endpoint tag trail the
    // forwarded get by one cycle, matching the PE's read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            g         <= '0;
            last      <= LAST_INIT;
            burst_cnt <= '0;
            rd_valid  <= 1'b0;
            rd_ep     <= '0;
        end else begin
            state     <= state_nxt;
            g         <= g_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
            rd_valid  <= fwd_get;
            if (fwd_get) begin
                rd_ep <= g;
            end
        end
    end

endmodule

// File: doc/usb_fs_out_arb.md
# usb_fs_out_arb

Round-robin arbiter that shares the OUT protocol engine's single endpoint read port between up to 16 endpoint consumers. It sits between the OUT PE (`out_ep_data_avail`, `out_ep_data_get`, `out_ep_grant`, `out_ep_data`) and the per-endpoint consumer logic such as the serial bridge and the control endpoint. It drives the one-hot grant that selects which endpoint buffer the PE reads. It also forwards consumer get strobes, caps burst length for fairness, and tags each returned byte with its endpoint number.

## Interface
Parameters:
- `NUM_OUT_EPS`, default 1: number of requesters/endpoints, 1..16.
- `MAX_BURST`, default 32: maximum gets per grant while another requester is eligible, 1..63.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rd_req` in NUM_OUT_EPS: consumer i requests the read port.
- `rd_get` in NUM_OUT_EPS: consumer i pulls one byte; ignored unless granted.
- `rd_grant` out NUM_OUT_EPS: one-hot grant to consumers.
- `rd_valid` out 1: byte on `out_ep_data` is valid this cycle.
- `rd_ep` out 4: endpoint number of the byte flagged by `rd_valid`.
- `out_ep_data_avail` in NUM_OUT_EPS: PE has unread bytes for endpoint i.
- `out_ep_grant` out NUM_OUT_EPS: one-hot endpoint select to PE; identical to `rd_grant`.
- `out_ep_data_get` out NUM_OUT_EPS: forwarded get strobe to PE.

## Operation
- Eligible(i) = `rd_req[i] && out_ep_data_avail[i]`.
- States:
  - IDLE: no grant.
    - If any requester is eligible, register the winner g and go to BUSY.
    - Winner is the first eligible index scanning upward from `last+1`, wrapping modulo NUM_OUT_EPS.
    - Clear `burst_cnt`.
  - BUSY: `rd_grant`/`out_ep_grant` = one-hot(g).
    - Forward `out_ep_data_get[g] = rd_get[g] && out_ep_data_avail[g] && burst_cnt < MAX_BURST`. All other get bits are 0.
    - Each forwarded get increments `burst_cnt` (6 bit, saturating at MAX_BURST).
    - Exit to RELEASE and set `last <= g` when any of these holds:
      - `!rd_req[g]`;
      - `!out_ep_data_avail[g]`;
      - `burst_cnt == MAX_BURST` and some other requester is eligible.
    - At `burst_cnt == MAX_BURST` with no other eligible requester, clear `burst_cnt` and stay in BUSY.
  - RELEASE: one dead cycle with all grants 0, then IDLE. This keeps the PE's grant-decoded read address stable between owners.
- Forwarded get at cycle t produces the consumed byte on `out_ep_data` at t+1. `rd_valid` is registered from the forwarded get, and `rd_ep` is registered from g in that same cycle.
- `rd_get` from an ungranted consumer is dropped silently.
- Requesters with `rd_req` high but `out_ep_data_avail` low are never granted.

## Timing
- Reset (async assert, sync deassert handled upstream): state IDLE, `last` = NUM_OUT_EPS-1 so endpoint 0 wins first, `burst_cnt` 0.
  - All outputs 0: `rd_grant`, `out_ep_grant`, `out_ep_data_get`, `rd_valid`, `rd_ep`.
- Grant latency: eligible sampled in IDLE at cycle t, grant high from t+1.
- First get is forwarded combinationally in any BUSY cycle.
- Data latency: forwarded get at t gives `rd_valid` = 1 and byte on `out_ep_data` at t+1.
- Handover: exit decision at t gives grant low at t+1 (RELEASE) and IDLE at t+2. The next grant is earliest at t+3.
- Simultaneous events:
  - Exit condition and `rd_get` in the same BUSY cycle: the get is still forwarded if `avail` and burst limit allow.
  - Reset asserted mid-burst: grants and gets drop immediately (async), and any pending `rd_valid` is lost.
- Single requester: never starved by the burst cap; the burst counter simply wraps.
- `NUM_OUT_EPS` = 1: round-robin degenerates to always index 0.

## Test plan
- After reset, all outputs are 0. Raise `rd_req[0]` with `avail[0]`=1 at cycle 5: `rd_grant`=`4'b0001` at cycle 6, and pulses on `rd_get[0]` give `rd_valid` one cycle later with `rd_ep`=0.
- NUM_OUT_EPS=4, `rd_req`=`4'b1010`, all avail, consumers hold get continuously: grants alternate ep1, ep3, ep1, each for exactly MAX_BURST=32 forwarded gets with a 2-cycle gap.
- Only ep2 requests, MAX_BURST=4, 10 gets: grant stays on ep2 throughout and 10 `rd_valid` pulses occur with no RELEASE.
- BUSY on ep0: drop `avail[0]` at cycle t. `out_ep_data_get[0]` is 0 from cycle t, grant is 0 at t+1, and ep1 (requesting) is granted at t+3.
- `rd_get[3]` pulsed while ep1 is granted: `out_ep_data_get` stays 0 and `rd_valid` stays 0.
- Assert reset mid-burst on ep1: grant and get clear without a clock edge. After release, ep0 wins if it is requesting.
